pc_flow_unit: RTL and testbench

//  Parametrised program-counter and next-PC unit for the single-cycle CPU.

---
 rtl/pc_flow_unit.sv | 134 +++++++++++++
 tb/tb_pc_flow_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_flow_unit.sv
// pc_flow_unit: program counter and next-PC selection for the single-cycle CPU.
// Holds the PC, picks sequential / jump / beq / bne / return targets, stalls on
// instruction-memory busywait, counts retired instructions (saturating) and
// flags a one-cycle redirect after each taken flow change.
// Optional feature: define PC_FLOW_LINK_EN to enable call/return via a link register.
//
// state | meaning
// 00    | RST   : first cycle after reset, PC held at RESET_VEC, nothing retires
// 01    | RUN   : fetching, PC advances whenever busywait is low
// 10    | STALL : imem busy, PC / counter / redirect / link held
// 11    | (unreachable) recovers to RUN with PC held
module pc_flow_unit #(
  parameter int              PC_W      = 32,
  parameter int              OFF_W     = 8,
  parameter int              INSTR_B   = 4,
  parameter logic [PC_W-1:0] RESET_VEC = '0,
  parameter int              CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             busywait_i,
  input  logic             jump_i,
  input  logic             branch_eq_i,
  input  logic             branch_ne_i,
  input  logic             zero_i,
  input  logic [OFF_W-1:0] offset_i,
  input  logic             link_call_i,
  input  logic             link_ret_i,
  output logic [PC_W-1:0]  pc_o,
  output logic [PC_W-1:0]  pc_seq_o,
  output logic             redirect_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] retired_o,
  output logic [PC_W-1:0]  link_pc_o
);

  localparam logic [1:0] ST_RST   = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_STALL = 2'b10;
  localparam int         SHIFT    = $clog2(INSTR_B);

  logic [1:0]       state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             redirect_q, redirect_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [PC_W-1:0]  link_q, link_d;

  logic             call_en, ret_en;
  logic [PC_W-1:0]  pc_seq, off_ext, target;
  logic             advance;

`ifdef PC_FLOW_LINK_EN
  assign call_en = link_call_i;
  assign ret_en  = link_ret_i;
`else
  // Link inputs exist in both builds but are inert here.
  logic unused_link;
  assign unused_link = link_call_i ^ link_ret_i;
  assign call_en = 1'b0;
  assign ret_en  = 1'b0;
`endif

  // Sequential and offset targets; all arithmetic wraps modulo 2^PC_W.
  assign pc_seq  = pc_q + PC_W'(INSTR_B);
  assign off_ext = PC_W'($signed(offset_i));
  assign target  = pc_seq + (off_ext << SHIFT);
  assign advance = ((state_q == ST_RUN) || (state_q == ST_STALL)) && !busywait_i;

  // Next-state, next-PC selection and counter update.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redirect_d = redirect_q;
    retired_d  = retired_q;
    link_d     = link_q;

    case (state_q)
      ST_RST:   state_d = ST_RUN;
      ST_RUN:   state_d = busywait_i ? ST_STALL : ST_RUN;
      ST_STALL: state_d = busywait_i ? ST_STALL : ST_RUN;
      default:  state_d = ST_RUN;
    endcase

    if (advance) begin
      redirect_d = 1'b1;
      if (ret_en) begin
        pc_d = link_q;
      end else if (jump_i || call_en) begin
        pc_d = target;
        if (call_en) link_d = pc_seq;
      end else if (branch_eq_i) begin
        // beq wins over bne when both are set; bne is not consulted.
        if (zero_i) begin
          pc_d = target;
        end else begin
          pc_d       = pc_seq;
          redirect_d = 1'b0;
        end
      end else if (branch_ne_i && !zero_i) begin
        pc_d = target;
      end else begin
        pc_d       = pc_seq;
        redirect_d = 1'b0;
      end

      if (retired_q != {CNT_W{1'b1}}) retired_d = retired_q + 1'b1;
    end
  end

  // State registers with immediate reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_RST;
      pc_q       <= RESET_VEC;
      redirect_q <= 1'b0;
      retired_q  <= '0;
      link_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
      retired_q  <= retired_d;
      link_q     <= link_d;
    end
  end

  assign pc_o       = pc_q;
  assign pc_seq_o   = pc_seq;
  assign redirect_o = redirect_q;
  assign state_o    = state_q;
  assign retired_o  = retired_q;
  assign link_pc_o  = link_q;

endmodule

// File: tb/tb_pc_flow_unit.sv
// Directed bench for pc_flow_unit: a vector table for the main flow plus
// hand sequences for call/return, async reset mid-stall and a narrow
// wrap/saturation instance.
module tb_pc_flow_unit;

  typedef struct {
    logic        busy, jump, beq, bne, zero;
    logic [7:0]  off;
    logic [31:0] pc;
    logic [1:0]  st;
    logic        redir;
    logic [15:0] ret_cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busy = 0, jump = 0, beq = 0, bne = 0, zero = 0, call = 0, ret = 0;
  logic [7:0]  off = '0;
  logic [31:0] pc, pc_seq, link_pc;
  logic        redir;
  logic [1:0]  st;
  logic [15:0] retired;

  logic        rst2 = 1'b1;
  logic [7:0]  pc2, pc_seq2, link_pc2;
  logic        redir2;
  logic [1:0]  st2;
  logic [1:0]  retired2;

  int passed = 0;
  int total  = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  pc_flow_unit dut (
    .clk_i(clk), .rst_i(rst), .busywait_i(busy), .jump_i(jump),
    .branch_eq_i(beq), .branch_ne_i(bne), .zero_i(zero), .offset_i(off),
    .link_call_i(call), .link_ret_i(ret),
    .pc_o(pc), .pc_seq_o(pc_seq), .redirect_o(redir), .state_o(st),
    .retired_o(retired), .link_pc_o(link_pc)
  );

  pc_flow_unit #(.PC_W(8), .OFF_W(8), .INSTR_B(4), .RESET_VEC(8'hF8), .CNT_W(2)) dut_small (
    .clk_i(clk), .rst_i(rst2), .busywait_i(1'b0), .jump_i(1'b0),
    .branch_eq_i(1'b0), .branch_ne_i(1'b0), .zero_i(1'b0), .offset_i(8'h00),
    .link_call_i(1'b0), .link_ret_i(1'b0),
    .pc_o(pc2), .pc_seq_o(pc_seq2), .redirect_o(redir2), .state_o(st2),
    .retired_o(retired2), .link_pc_o(link_pc2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic clr_in();
    busy = 0; jump = 0; beq = 0; bne = 0; zero = 0; call = 0; ret = 0; off = '0;
  endtask

  task automatic do_reset();
    clr_in();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic addv(input logic b, j, e, n, z, input logic [7:0] o,
                      input logic [31:0] p, input logic [1:0] s, input logic r,
                      input logic [15:0] c);
    vec_t v;
    v.busy = b; v.jump = j; v.beq = e; v.bne = n; v.zero = z; v.off = o;
    v.pc = p; v.st = s; v.redir = r; v.ret_cnt = c;
    vq.push_back(v);
  endtask

  initial begin
    //   busy jmp beq bne zero off     pc   st     rd cnt
    addv(0, 0, 0, 0, 0, 8'h00,  0, 2'b01, 0,  0);  // boot cycle holds RESET_VEC
    addv(0, 0, 0, 0, 0, 8'h00,  4, 2'b01, 0,  1);
    addv(0, 0, 0, 0, 0, 8'h00,  8, 2'b01, 0,  2);
    addv(0, 0, 0, 0, 0, 8'h00, 12, 2'b01, 0,  3);
    addv(0, 0, 0, 0, 0, 8'h00, 16, 2'b01, 0,  4);
    addv(0, 0, 0, 0, 0, 8'h00, 20, 2'b01, 0,  5);
    addv(0, 0, 0, 0, 0, 8'h00, 24, 2'b01, 0,  6);
    addv(0, 0, 0, 0, 0, 8'h00, 28, 2'b01, 0,  7);
    addv(0, 0, 1, 0, 0, 8'h02, 32, 2'b01, 0,  8);  // beq not taken
    addv(0, 0, 1, 0, 1, 8'h02, 44, 2'b01, 1,  9);  // beq taken: 36+8
    addv(0, 0, 0, 1, 0, 8'hFC, 32, 2'b01, 1, 10);  // bne taken: 48-16
    addv(0, 0, 0, 0, 0, 8'h00, 36, 2'b01, 0, 11);
    addv(0, 0, 0, 1, 1, 8'hFC, 40, 2'b01, 0, 12);  // bne not taken
    addv(0, 0, 1, 1, 0, 8'h02, 44, 2'b01, 0, 13);  // both: beq decides, not taken
    addv(0, 1, 0, 0, 0, 8'hFE, 40, 2'b01, 1, 14);  // jump back: 48-8
    addv(0, 1, 1, 0, 1, 8'h03, 56, 2'b01, 1, 15);  // jump: 44+12
    addv(1, 1, 0, 0, 0, 8'h01, 56, 2'b10, 1, 15);  // stall, redirect held
    addv(1, 1, 0, 0, 0, 8'h01, 56, 2'b10, 1, 15);
    addv(1, 1, 0, 0, 0, 8'h01, 56, 2'b10, 1, 15);
    addv(0, 1, 0, 0, 0, 8'h01, 64, 2'b01, 1, 16);  // release: 60+4
    addv(0, 0, 0, 0, 0, 8'h00, 68, 2'b01, 0, 17);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc, 32'd0);
    chk("rst_state", {30'd0, st}, 32'd0);
    chk("rst_redirect", {31'd0, redir}, 32'd0);
    chk("rst_retired", {16'd0, retired}, 32'd0);
    chk("rst_link", link_pc, 32'd0);
    chk("rst_pc_seq", pc_seq, 32'd4);
    rst = 1'b0;

    foreach (vq[i]) begin
      busy = vq[i].busy; jump = vq[i].jump; beq = vq[i].beq;
      bne = vq[i].bne; zero = vq[i].zero; off = vq[i].off;
      step();
      chk($sformatf("v%0d_pc", i), pc, vq[i].pc);
      chk($sformatf("v%0d_state", i), {30'd0, st}, {30'd0, vq[i].st});
      chk($sformatf("v%0d_redirect", i), {31'd0, redir}, {31'd0, vq[i].redir});
      chk($sformatf("v%0d_retired", i), {16'd0, retired}, {16'd0, vq[i].ret_cnt});
      chk($sformatf("v%0d_link", i), link_pc, 32'd0);
    end
    clr_in();

    // Call / return sequence from PC=20
    do_reset();
    repeat (6) step();
    chk("link_pre_pc", pc, 32'd20);
    call = 1; off = 8'd5;
    step();
`ifdef PC_FLOW_LINK_EN
    chk("call_pc", pc, 32'd44);
    chk("call_link", link_pc, 32'd24);
    chk("call_redirect", {31'd0, redir}, 32'd1);
`else
    chk("call_pc", pc, 32'd24);
    chk("call_link", link_pc, 32'd0);
    chk("call_redirect", {31'd0, redir}, 32'd0);
`endif
    call = 0; ret = 1; off = '0;
    step();
`ifdef PC_FLOW_LINK_EN
    chk("ret_pc", pc, 32'd24);
    chk("ret_redirect", {31'd0, redir}, 32'd1);
`else
    chk("ret_pc", pc, 32'd28);
    chk("ret_redirect", {31'd0, redir}, 32'd0);
`endif
    call = 1; ret = 1; off = 8'd5;
    step();
`ifdef PC_FLOW_LINK_EN
    chk("both_pc", pc, 32'd24);
    chk("both_link", link_pc, 32'd24);
`else
    chk("both_pc", pc, 32'd32);
    chk("both_link", link_pc, 32'd0);
`endif
    clr_in();

    // Async reset in the middle of a stall
    busy = 1;
    repeat (2) step();
    chk("stall_state", {30'd0, st}, 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("async_pc", pc, 32'd0);
    chk("async_state", {30'd0, st}, 32'd0);
    chk("async_retired", {16'd0, retired}, 32'd0);
    chk("async_redirect", {31'd0, redir}, 32'd0);
    chk("async_link", link_pc, 32'd0);
    busy = 0; jump = 1; off = 8'd5;
    #1 rst = 1'b0;
    step();
    chk("boot_after_rst_pc", pc, 32'd0);
    chk("boot_after_rst_state", {30'd0, st}, 32'd1);
    clr_in();

    // Narrow instance: PC wraps, counter saturates
    rst2 = 1'b0;
    step();
    chk("w_boot_pc", {24'd0, pc2}, 32'hF8);
    step();
    chk("w_pc_fc", {24'd0, pc2}, 32'hFC);
    step();
    chk("w_pc_wrap", {24'd0, pc2}, 32'h00);
    chk("w_retired2", {30'd0, retired2}, 32'd2);
    step();
    chk("w_retired3", {30'd0, retired2}, 32'd3);
    step();
    chk("w_retired_sat", {30'd0, retired2}, 32'd3);
    chk("w_pc_08", {24'd0, pc2}, 32'h08);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
